// File: rtl/fpu_pkg.sv
// Shared FPU opcode map and opcode classification helpers used by the writeback stage.
package fpu_pkg;

    localparam logic [5:0] FOP_ADD_D  = 6'b000000;
    localparam logic [5:0] FOP_ADD_S  = 6'b000001;
    localparam logic [5:0] FOP_SUB_D  = 6'b000010;
    localparam logic [5:0] FOP_SUB_S  = 6'b000011;
    localparam logic [5:0] FOP_MUL_D  = 6'b000100;
    localparam logic [5:0] FOP_MUL_S  = 6'b000101;
    localparam logic [5:0] FOP_DIV_D  = 6'b000110;
    localparam logic [5:0] FOP_DIV_S  = 6'b000111;
    localparam logic [5:0] FOP_SQRT_D = 6'b001000;
    localparam logic [5:0] FOP_SQRT_S = 6'b001001;
    localparam logic [5:0] FOP_MADD_D = 6'b010000;
    localparam logic [5:0] FOP_MADD_S = 6'b010001;
    localparam logic [5:0] FOP_MSUB_D = 6'b010010;
    localparam logic [5:0] FOP_MSUB_S = 6'b010011;
    localparam logic [5:0] FOP_FEQ_D  = 6'b010100;
    localparam logic [5:0] FOP_FEQ_S  = 6'b010101;
    localparam logic [5:0] FOP_FLT_D  = 6'b010110;
    localparam logic [5:0] FOP_FLT_S  = 6'b010111;
    localparam logic [5:0] FOP_FLE_D  = 6'b011000;
    localparam logic [5:0] FOP_FLE_S  = 6'b011001;
    localparam logic [5:0] FOP_MIN_D  = 6'b011010;
    localparam logic [5:0] FOP_MIN_S  = 6'b011011;
    localparam logic [5:0] FOP_MAX_D  = 6'b011100;
    localparam logic [5:0] FOP_MAX_S  = 6'b011101;
    localparam logic [5:0] FOP_SGNJ_D = 6'b011110;
    localparam logic [5:0] FOP_SGNJ_S = 6'b011111;
    localparam logic [5:0] FOP_FMV_XD = 6'b100000;
    localparam logic [5:0] FOP_FMV_DX = 6'b100001;

    localparam logic [31:0] NAN_BOX_HI = 32'hFFFFFFFF;

    // Arithmetic-style ops whose result lands in the FP file; op[0] selects single precision.
    function automatic logic is_fp_arith(input logic [5:0] op);
        return (op inside {[FOP_ADD_D:FOP_SQRT_S], [FOP_MADD_D:FOP_MSUB_S], [FOP_MIN_D:FOP_SGNJ_S]});
    endfunction

    function automatic logic is_single(input logic [5:0] op);
        return is_fp_arith(op) && op[0];
    endfunction

    function automatic logic is_cmp(input logic [5:0] op);
        return (op inside {[FOP_FEQ_D:FOP_FLE_S]});
    endfunction

    function automatic logic is_int_dest(input logic [5:0] op);
        return is_cmp(op) || (op == FOP_FMV_XD);
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return is_fp_arith(op) || is_cmp(op) || (op == FOP_FMV_XD) || (op == FOP_FMV_DX);
    endfunction

endpackage

// File: rtl/fpu_wb_fifo.sv
// Small synchronous queue with separate occupancy count, flush, and a hold register
// so the head output keeps its last value while the queue is empty.
module fpu_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 70
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic [WIDTH-1:0] hold_d, hold_q;
    logic             push_ok, pop_ok;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign push_ok   = push && !full && !flush;
    assign pop_ok    = pop && !empty && !flush;
    assign head_data = empty ? hold_q : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = head_data;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

    // Storage needs no reset: it is only visible through head_data while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fpu_writeback.sv
// FPU writeback stage: formats results at accept time and buffers them in a small queue.
// Optional FPU_WB_STATS_EN adds pop and stall counters as extra outputs.
module fpu_writeback
    import fpu_pkg::*;
#(
    parameter int BUS_WIDTH  = 64,
    parameter int OP_LEN     = 6,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_LEN-1:0]     in_op,
    input  logic [BUS_WIDTH-1:0]  in_result,
    input  logic [REG_ADDR_W-1:0] in_rd,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [BUS_WIDTH-1:0]  wb_data,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_to_int,
`ifdef FPU_WB_STATS_EN
    output logic [31:0]           wb_count,
    output logic [31:0]           stall_count,
`endif
    output logic                  illegal_op
);
    localparam int ENTRY_W = BUS_WIDTH + REG_ADDR_W + 1;

    logic                 accept, push, pop, full, empty;
    logic                 illegal_d, illegal_q;
    logic [BUS_WIDTH-1:0] fmt_data;
    logic [ENTRY_W-1:0]   head;

    assign in_ready = !full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && is_legal(in_op) && !flush;
    assign pop      = wb_valid && wb_ready;

    always_comb begin
        fmt_data = in_result;
        if (is_single(in_op)) begin
            fmt_data = {NAN_BOX_HI, in_result[31:0]};
        end else if (is_cmp(in_op)) begin
            fmt_data = {{(BUS_WIDTH-1){1'b0}}, in_result[0]};
        end
    end

    // Illegal ops are reported even when a flush drops them.
    always_comb begin
        illegal_d = accept && !is_legal(in_op);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else        illegal_q <= illegal_d;
    end

    fpu_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data ({is_int_dest(in_op), in_rd, fmt_data}),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head_data (head)
    );

    assign wb_valid   = !empty;
    assign wb_to_int  = head[ENTRY_W-1];
    assign wb_rd      = head[BUS_WIDTH +: REG_ADDR_W];
    assign wb_data    = head[BUS_WIDTH-1:0];
    assign illegal_op = illegal_q;

`ifdef FPU_WB_STATS_EN
    logic [31:0] wb_count_d, wb_count_q;
    logic [31:0] stall_count_d, stall_count_q;

    always_comb begin
        wb_count_d    = wb_count_q + 32'(pop && !flush);
        stall_count_d = stall_count_q + 32'(in_valid && !in_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_count_q    <= '0;
            stall_count_q <= '0;
        end else begin
            wb_count_q    <= wb_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign wb_count    = wb_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fpu_writeback.sv
// Directed bench for fpu_writeback: a queue-based reference model checked every cycle,
// plus literal expectations taken from hand-worked vectors.
module tb_fpu_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [63:0] in_result;
    logic [4:0]  in_rd;
    logic        wb_valid;
    logic        wb_ready;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_to_int;
    logic        illegal_op;
`ifdef FPU_WB_STATS_EN
    logic [31:0] wb_count;
    logic [31:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    always #5 clk = ~clk;

    fpu_writeback dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_result  (in_result),
        .in_rd      (in_rd),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd),
        .wb_to_int  (wb_to_int),
`ifdef FPU_WB_STATS_EN
        .wb_count   (wb_count),
        .stall_count(stall_count),
`endif
        .illegal_op (illegal_op)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        to_int;
    } ent_t;

    ent_t q[$];
    ent_t last = '0;
    bit   exp_ill = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference formatting rules written directly from the opcode table.
    function automatic void fmt(input logic [5:0] op, input logic [63:0] r, input logic [4:0] rd,
                                output bit legal, output ent_t e);
        int o;
        o = int'(op);
        legal = 1'b1;
        e.data = r;
        e.rd = rd;
        e.to_int = 1'b0;
        if (o <= 9 || (o >= 16 && o <= 19) || (o >= 26 && o <= 31)) begin
            if (o % 2 == 1) e.data = {32'hFFFFFFFF, r[31:0]};
        end else if (o >= 20 && o <= 25) begin
            e.data = {63'd0, r[0]};
            e.to_int = 1'b1;
        end else if (o == 32) begin
            e.to_int = 1'b1;
        end else if (o != 33) begin
            legal = 1'b0;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            last = '0;
            exp_ill = 1'b0;
        end else begin
            bit   acc, pop_m, legal;
            ent_t e;
            acc = in_valid && (q.size() < 2);
            pop_m = (q.size() > 0) && wb_ready;
            fmt(in_op, in_result, in_rd, legal, e);
            if (q.size() > 0) last = q[0];
            exp_ill = acc && !legal;
            if (flush) begin
                q.delete();
            end else begin
                if (pop_m) void'(q.pop_front());
                if (acc && legal) q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            ent_t h;
            h = (q.size() > 0) ? q[0] : last;
            chk("m_valid", 64'(wb_valid), 64'(q.size() > 0));
            chk("m_in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("m_data", wb_data, h.data);
            chk("m_rd", 64'(wb_rd), 64'(h.rd));
            chk("m_to_int", 64'(wb_to_int), 64'(h.to_int));
            chk("m_illegal", 64'(illegal_op), 64'(exp_ill));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [63:0] r, input logic [4:0] rd);
        in_valid = v;
        in_op = op;
        in_result = r;
        in_rd = rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        wb_ready = 1'b0;
        drive(1'b0, 6'd0, 64'd0, 5'd0);
        step();
        step();
        chk("rst_valid", 64'(wb_valid), 64'd0);
        chk("rst_data", wb_data, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_illegal", 64'(illegal_op), 64'd0);
        rst_n = 1'b1;
        step();

        // single-precision add is NaN-boxed
        wb_ready = 1'b1;
        drive(1'b1, 6'b000001, 64'h0000_0000_3F80_0000, 5'd3);
        step();
        drive(1'b0, 6'd0, 64'd0, 5'd0);
        chk("sadd_valid", 64'(wb_valid), 64'd1);
        chk("sadd_data", wb_data, 64'hFFFF_FFFF_3F80_0000);
        chk("sadd_rd", 64'(wb_rd), 64'd3);
        chk("sadd_to_int", 64'(wb_to_int), 64'd0);
        step();
        chk("sadd_hold", wb_data, 64'hFFFF_FFFF_3F80_0000);

        // comparisons go to the integer file as 0/1
        drive(1'b1, 6'b010110, 64'h1, 5'd5);
        step();
        chk("flt_data", wb_data, 64'h1);
        chk("flt_to_int", 64'(wb_to_int), 64'd1);
        drive(1'b1, 6'b010111, 64'hFFFF_FFFF_0000_0000, 5'd6);
        step();
        drive(1'b0, 6'd0, 64'd0, 5'd0);
        chk("flts_data", wb_data, 64'h0);
        step();

        // backpressure with three doubles
        wb_ready = 1'b0;
        drive(1'b1, 6'b000000, 64'hA, 5'd1);
        step();
        drive(1'b1, 6'b000000, 64'hB, 5'd2);
        step();
        drive(1'b1, 6'b000000, 64'hC, 5'd3);
        chk("bp_full", 64'(in_ready), 64'd0);
        step();
        chk("bp_head_a", wb_data, 64'hA);
        wb_ready = 1'b1;
        step();
        chk("bp_head_b", wb_data, 64'hB);
        step();
        drive(1'b0, 6'd0, 64'd0, 5'd0);
        chk("bp_head_c", wb_data, 64'hC);
        chk("bp_count1", 64'(wb_valid), 64'd1);
        step();
        chk("bp_empty", 64'(wb_valid), 64'd0);

        // illegal opcode
        drive(1'b1, 6'b111111, 64'h55, 5'd9);
        step();
        drive(1'b0, 6'd0, 64'd0, 5'd0);
        chk("ill_pulse", 64'(illegal_op), 64'd1);
        chk("ill_nostore", 64'(wb_valid), 64'd0);
        step();
        chk("ill_one_cycle", 64'(illegal_op), 64'd0);

        // flush with two queued entries and a simultaneous accept/pop
        wb_ready = 1'b0;
        drive(1'b1, 6'b000001, 64'h1234_5678_9ABC_DEF0, 5'd10);
        step();
        drive(1'b1, 6'b100001, 64'h0123_4567_89AB_CDEF, 5'd11);
        step();
        chk("fl_pre_data", wb_data, 64'hFFFF_FFFF_9ABC_DEF0);
        flush = 1'b1;
        wb_ready = 1'b1;
        drive(1'b1, 6'b000000, 64'h77, 5'd12);
        step();
        flush = 1'b0;
        drive(1'b0, 6'd0, 64'd0, 5'd0);
        chk("fl_valid", 64'(wb_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        flush = 1'b1;
        drive(1'b1, 6'b001010, 64'h1, 5'd1);
        step();
        flush = 1'b0;
        drive(1'b0, 6'd0, 64'd0, 5'd0);
        chk("fl_ill_pulse", 64'(illegal_op), 64'd1);

        // streaming table with a ready pattern; the model tracks drops and stalls
        for (int i = 0; i < 14; i++) begin
            logic [5:0] ops [14];
            ops = '{6'd0, 6'd1, 6'd9, 6'd16, 6'd21, 6'd24, 6'd26, 6'd31,
                    6'd32, 6'd33, 6'd10, 6'd15, 6'd34, 6'd19};
            wb_ready = (i % 3 != 0);
            drive(1'b1, ops[i], 64'hDEAD_BEEF_CAFE_F00D ^ 64'(i * 64'h0101_0000_0001), 5'(i));
            step();
        end
        drive(1'b0, 6'd0, 64'd0, 5'd0);
        wb_ready = 1'b1;
        step();
        step();
        step();

        // fmv.x.d is routed to the integer file unchanged
        drive(1'b1, 6'b100000, 64'h8000_0000_0000_0001, 5'd31);
        step();
        drive(1'b0, 6'd0, 64'd0, 5'd0);
        chk("fmvxd_data", wb_data, 64'h8000_0000_0000_0001);
        chk("fmvxd_to_int", 64'(wb_to_int), 64'd1);
        step();

        // asynchronous reset with one entry queued
        wb_ready = 1'b0;
        drive(1'b1, 6'b000000, 64'h77, 5'd7);
        step();
        drive(1'b0, 6'd0, 64'd0, 5'd0);
        chk("ar_pre_valid", 64'(wb_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(wb_valid), 64'd0);
        chk("ar_data", wb_data, 64'd0);
        chk("ar_rd", 64'(wb_rd), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("ar_post_valid", 64'(wb_valid), 64'd0);
        chk("ar_post_ready", 64'(in_ready), 64'd1);
        wb_ready = 1'b1;
        drive(1'b1, 6'b100001, 64'h5, 5'd2);
        step();
        drive(1'b0, 6'd0, 64'd0, 5'd0);
        chk("ar_resume_data", wb_data, 64'h5);
        chk("ar_resume_to_int", 64'(wb_to_int), 64'd0);
        step();
        step();

        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
